sm3_cf_ctrl: RTL and testbench

// Iterative SM3 compression-function engine and round scheduler. Accepts one 512-bit padded

---
 rtl/sm3_cf_ctrl_if.sv | 23 ++
 rtl/sm3_cf_ctrl.sv | 120 ++++++++++++
 tb/tb_sm3_cf_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sm3_cf_ctrl_if.sv
// Handshake bundle between the SM3 block feeder, the compression engine and the digest register.
// The engine connects through the slave modport; the feeder/digest side uses master.
interface sm3_cf_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] v_in;
  logic [511:0] blk_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] v_out;
  logic         busy;
  logic [6:0]   round;

  modport master (
    output in_valid, v_in, blk_in, out_ready,
    input  in_ready, out_valid, v_out, busy, round
  );

  modport slave (
    input  in_valid, v_in, blk_in, out_ready,
    output in_ready, out_valid, v_out, busy, round
  );
endinterface

// File: rtl/sm3_cf_ctrl.sv
// Iterative SM3 compression function: one round per clock, message expansion done on the fly
// through a 16-word sliding window, result V_{i+1} held until the consumer takes it.
module sm3_cf_ctrl #(
  parameter logic [31:0] T_LO     = 32'h79cc4519,
  parameter logic [31:0] T_HI     = 32'h7a879d8a,
  parameter logic [6:0]  J_SWITCH = 7'd16
) (
  input logic          clk,
  input logic          rst,
  sm3_cf_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [6:0]          round_q, round_d;
  logic [7:0][31:0]    work_q, work_d;
  logic [0:15][31:0]   win_q, win_d;
  logic [255:0]        vSave_q, vSave_d;
  logic [255:0]        vOut_q, vOut_d;

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] a12, tj, tRot, ss1, ss2, ffVal, ggVal, tt1, tt2, wNew;
  logic        lowRound;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

  // A is the most significant word, matching the v_in/v_out word order.
  assign {a, b, c, d, e, f, g, h} = work_q;

  always_comb begin
    lowRound = (round_q < J_SWITCH);
    a12      = rotl(a, 5'd12);
    tj       = lowRound ? T_LO : T_HI;
    tRot     = rotl(tj, round_q[4:0]);
    ss1      = rotl(a12 + e + tRot, 5'd7);
    ss2      = ss1 ^ a12;
    ffVal    = lowRound ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
    ggVal    = lowRound ? (e ^ f ^ g) : ((e & f) | (~e & g));
    tt1      = ffVal + d + ss2 + (win_q[0] ^ win_q[4]);
    tt2      = ggVal + h + ss1 + win_q[0];
    wNew     = p1(win_q[0] ^ win_q[7] ^ rotl(win_q[13], 5'd15))
               ^ rotl(win_q[3], 5'd7) ^ win_q[10];
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    work_d  = work_q;
    win_d   = win_q;
    vSave_d = vSave_q;
    vOut_d  = vOut_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.v_in;
          vSave_d = bus.v_in;
          win_d   = bus.blk_in;
          round_d = 7'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
        win_d  = {win_q[1:15], wNew};
        if (round_q == 7'd63) begin
          round_d = 7'd0;
          state_d = FIN;
        end else begin
          round_d = round_q + 7'd1;
        end
      end
      FIN: begin
        vOut_d  = work_q ^ vSave_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      work_q  <= '0;
      win_q   <= '0;
      vSave_q <= '0;
      vOut_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      work_q  <= work_d;
      win_q   <= win_d;
      vSave_q <= vSave_d;
      vOut_q  <= vOut_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.round     = round_q;
  assign bus.v_out     = vOut_q;

endmodule

// File: tb/tb_sm3_cf_ctrl.sv
// Bench for sm3_cf_ctrl: known-answer vectors, handshake corner cases and random blocks
// compared against a plain array-based SM3 compression model.
module tb_sm3_cf_ctrl;
  localparam logic [31:0]  T_LO = 32'h79cc4519;
  localparam logic [31:0]  T_HI = 32'h7a879d8a;
  localparam logic [255:0] IV   = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG   = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [511:0] ABCD_BLK1 = {16{32'h61626364}};
  localparam logic [511:0] ABCD_BLK2 = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] ABCD_DIG  = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm3_cf_ctrl_if bus ();
  sm3_cf_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] vIn;
    logic [511:0] blk;
    bit           chain;
    bit           hasExp;
    logic [255:0] expOut;
    int           mode;   // 0 plain, 1 in_valid pokes while busy, 2 reset at round 30
    int           stall;  // cycles out_ready is held low after out_valid
  } vec_t;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int k = n % 32;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] refP0(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction

  function automatic logic [31:0] refP1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  // Textbook SM3 compression: full 68-word expansion up front, then 64 rounds on a word array.
  function automatic logic [255:0] refCompress(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [0:67];
    logic [31:0] r [0:7];
    logic [31:0] t, ss1, ss2, ff, gg, tt1, tt2;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 68; i++)
      w[i] = refP1(w[i-16] ^ w[i-9] ^ rl(w[i-3], 15)) ^ rl(w[i-13], 7) ^ w[i-6];
    for (int i = 0; i < 8; i++) r[i] = v[255 - 32*i -: 32];
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? T_LO : T_HI;
      ss1 = rl(rl(r[0], 12) + r[4] + rl(t, j), 7);
      ss2 = ss1 ^ rl(r[0], 12);
      ff  = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
      gg  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
      tt1 = ff + r[3] + ss2 + (w[j] ^ w[j+4]);
      tt2 = gg + r[7] + ss1 + w[j];
      r[3] = r[2]; r[2] = rl(r[1], 9);  r[1] = r[0]; r[0] = tt1;
      r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4]; r[4] = refP0(tt2);
    end
    return {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]} ^ v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Feeds one block and follows it to the output handshake; all sampling on the falling edge.
  task automatic applyStimulus(input string name, input logic [255:0] vIn, input logic [511:0] blk,
                               input logic [255:0] exp, input int mode, input int stall,
                               output logic [255:0] got, output bit aborted);
    int c;
    int roundBad;
    int bpBad;
    int extra;
    aborted = 1'b0;
    got = '0;
    bus.out_ready = 1'b0;
    c = 0;
    while (!bus.in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput({name, "_idle_ready"}, 256'(bus.in_ready), 256'd1);
    bus.v_in = vIn;
    bus.blk_in = blk;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    roundBad = 0;
    c = 0;
    while (!bus.out_valid && c < 200) begin
      if (c < 64 && (bus.round !== 7'(c) || bus.busy !== 1'b1)) roundBad++;
      if (mode == 1 && (c == 10 || c == 40)) begin
        checkOutput($sformatf("%s_poke%0d_ready", name, c), 256'(bus.in_ready), 256'd0);
        bus.v_in = ~vIn;
        bus.blk_in = ~blk;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (mode == 2 && c == 30) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput({name, "_rst_in_ready"}, 256'(bus.in_ready), 256'd1);
        checkOutput({name, "_rst_out_valid"}, 256'(bus.out_valid), 256'd0);
        checkOutput({name, "_rst_round"}, 256'(bus.round), 256'd0);
        checkOutput({name, "_rst_busy"}, 256'(bus.busy), 256'd0);
        aborted = 1'b1;
        return;
      end
      @(negedge clk);
      c++;
    end
    bus.in_valid = 1'b0;
    checkOutput({name, "_latency"}, 256'(c), 256'd65);
    checkOutput({name, "_round_seq_errs"}, 256'(roundBad), 256'd0);
    bpBad = 0;
    for (int s = 0; s < stall; s++) begin
      if (bus.v_out !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bpBad++;
      @(negedge clk);
    end
    if (stall > 0) checkOutput({name, "_stall_errs"}, 256'(bpBad), 256'd0);
    got = bus.v_out;
    bus.out_ready = 1'b1;
    bus.in_valid = (stall > 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput({name, "_post_out_valid"}, 256'(bus.out_valid), 256'd0);
    checkOutput({name, "_post_in_ready"}, 256'(bus.in_ready), 256'd1);
    checkOutput({name, "_post_busy"}, 256'(bus.busy), 256'd0);
    if (mode == 1) begin
      extra = 0;
      for (int s = 0; s < 70; s++) begin
        if (bus.out_valid) extra++;
        @(negedge clk);
      end
      checkOutput({name, "_no_second_out"}, 256'(extra), 256'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t         vecs [7];
    logic [255:0] vIn, exp, got, prevExp;
    logic [511:0] blk;
    bit           aborted;

    vecs[0] = '{IV, ABC_BLK, 1'b0, 1'b1, ABC_DIG, 0, 0};
    vecs[1] = '{IV, ABC_BLK, 1'b0, 1'b1, ABC_DIG, 0, 20};
    vecs[2] = '{IV, ABC_BLK, 1'b0, 1'b1, ABC_DIG, 1, 0};
    vecs[3] = '{IV, ABC_BLK, 1'b0, 1'b1, ABC_DIG, 2, 0};
    vecs[4] = '{IV, ABC_BLK, 1'b0, 1'b1, ABC_DIG, 0, 0};
    vecs[5] = '{IV, ABCD_BLK1, 1'b0, 1'b0, '0, 0, 0};
    vecs[6] = '{'0, ABCD_BLK2, 1'b1, 1'b1, ABCD_DIG, 0, 0};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.v_in = '0;
    bus.blk_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 256'(bus.in_ready), 256'd1);
    checkOutput("reset_out_valid", 256'(bus.out_valid), 256'd0);
    checkOutput("reset_busy", 256'(bus.busy), 256'd0);
    checkOutput("reset_round", 256'(bus.round), 256'd0);
    checkOutput("reset_v_out", bus.v_out, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    prevExp = '0;
    for (int i = 0; i < 7; i++) begin
      vIn = vecs[i].chain ? prevExp : vecs[i].vIn;
      exp = vecs[i].hasExp ? vecs[i].expOut : refCompress(vIn, vecs[i].blk);
      prevExp = exp;
      applyStimulus($sformatf("vec%0d", i), vIn, vecs[i].blk, exp, vecs[i].mode, vecs[i].stall,
                    got, aborted);
      if (!aborted) checkOutput($sformatf("vec%0d_digest", i), got, exp);
    end

    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 8; k++) vIn[32*k +: 32] = $urandom;
      for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom;
      exp = refCompress(vIn, blk);
      applyStimulus($sformatf("rnd%0d", n), vIn, blk, exp, 0, $urandom_range(0, 3), got, aborted);
      checkOutput($sformatf("rnd%0d_digest", n), got, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
